mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_if.sv | 12 +
 rtl/mdu.sv | 55 +++++
 tb/tb_mdu.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: MD operation codes and the multiply/divide result function shared by mdu
package mdu_pkg;
  localparam logic [2:0] MDOP_NONE  = 3'd0;
  localparam logic [2:0] MDOP_MULT  = 3'd1;
  localparam logic [2:0] MDOP_MULTU = 3'd2;
  localparam logic [2:0] MDOP_DIV   = 3'd3;
  localparam logic [2:0] MDOP_DIVU  = 3'd4;
  localparam logic [2:0] MDOP_MTHI  = 3'd5;
  localparam logic [2:0] MDOP_MTLO  = 3'd6;
  function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo);
    logic ovf;
    logic bz;
    logic [31:0] bs;
    ovf = op == MDOP_DIV && a == 32'h8000_0000 && b == 32'hffff_ffff;
    bz = b == 32'd0;
    bs = (ovf || bz) ? 32'd1 : b;
    return op == MDOP_MULT  ? {{32{a[31]}}, a} * {{32{b[31]}}, b} :
           op == MDOP_MULTU ? {32'd0, a} * {32'd0, b} :
           bz               ? hilo :
           ovf              ? {32'd0, a} :
           op == MDOP_DIV   ? {32'($signed(a) % $signed(bs)), 32'($signed(a) / $signed(bs))} :
           op == MDOP_DIVU  ? {a % bs, a / bs} : hilo;
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage MD request (start/mdop/a/b) and MD state (busy/hi/lo)
interface mdu_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, mdop, a, b, input busy, hi, lo);
  modport slave (input start, mdop, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; ports clk, reset (sync, active-high), md (mdu_if.slave)
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  md
);
  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic idle_start, go, commit;
  logic [63:0] res;
  always_comb begin
    idle_start = state_q == ST_IDLE && md.start;
    go = idle_start && (md.mdop == MDOP_MULT || md.mdop == MDOP_MULTU || md.mdop == MDOP_DIV || md.mdop == MDOP_DIVU);
    commit = state_q == ST_RUN && cnt_q == 4'd1;
    res = md_result(op_q, a_q, b_q, {hi_q, lo_q});
    state_d = go ? ST_RUN : commit ? ST_IDLE : state_q;
    cnt_d = go ? ((md.mdop == MDOP_DIV || md.mdop == MDOP_DIVU) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) :
            state_q == ST_RUN ? cnt_q - 4'd1 : cnt_q;
    op_d = go ? md.mdop : op_q;
    a_d = go ? md.a : a_q;
    b_d = go ? md.b : b_q;
    hi_d = idle_start && md.mdop == MDOP_MTHI ? md.a : commit ? res[63:32] : hi_q;
    lo_d = idle_start && md.mdop == MDOP_MTLO ? md.a : commit ? res[31:0] : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      op_q <= MDOP_NONE;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign md.busy = state_q == ST_RUN;
  assign md.hi = hi_q;
  assign md.lo = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against a cycle-level arithmetic model
module tb_mdu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_if mif ();
  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(mif));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic p_ok = 1'b0;
  longint sa, sb;
  logic [63:0] ua, ub;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && p_ok) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (mif.start) begin
      sa = 64'($signed(mif.a));
      sb = 64'($signed(mif.b));
      ua = 64'(mif.a);
      ub = 64'(mif.b);
      p_ok = 1'b1;
      case (mif.mdop)
        3'd1: begin {p_hi, p_lo} = sa * sb; m_rem = 5; end
        3'd2: begin {p_hi, p_lo} = ua * ub; m_rem = 5; end
        3'd3: begin
          m_rem = 10;
          p_ok = sb != 0;
          if (p_ok) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
        end
        3'd4: begin
          m_rem = 10;
          p_ok = ub != 0;
          if (p_ok) begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
        end
        3'd5: m_hi = mif.a;
        3'd6: m_lo = mif.a;
        default: ;
      endcase
    end
  end
  always @(posedge clk) begin
    #1;
    check("busy", 32'(mif.busy), 32'(m_rem > 0));
    check("hi", mif.hi, m_hi);
    check("lo", mif.lo, m_lo);
  end
  task automatic go(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    mif.start = 1'b1;
    mif.mdop = op;
    mif.a = x;
    mif.b = y;
    @(negedge clk);
    mif.start = 1'b0;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    while (mif.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [31:0] x, y;
    mif.start = 1'b0;
    mif.mdop = '0;
    mif.a = '0;
    mif.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(mif.busy), 0);
    check("rst_hi", mif.hi, 0);
    check("rst_lo", mif.lo, 0);
    reset = 1'b0;
    @(negedge clk);
    go(3'd1, 32'hffff_fffe, 32'd3);
    count_busy(n);
    check("mult_cycles", 32'(n), 5);
    check("mult_hi", mif.hi, 32'hffff_ffff);
    check("mult_lo", mif.lo, 32'hffff_fffa);
    go(3'd2, 32'hffff_ffff, 32'hffff_ffff);
    count_busy(n);
    check("multu_cycles", 32'(n), 5);
    check("multu_hi", mif.hi, 32'hffff_fffe);
    check("multu_lo", mif.lo, 32'h0000_0001);
    go(3'd3, 32'hffff_fff9, 32'd2);
    count_busy(n);
    check("div_cycles", 32'(n), 10);
    check("div_hi", mif.hi, 32'hffff_ffff);
    check("div_lo", mif.lo, 32'hffff_fffd);
    go(3'd4, 32'd7, 32'd0);
    count_busy(n);
    check("divu0_cycles", 32'(n), 10);
    check("divu0_hi", mif.hi, 32'hffff_ffff);
    check("divu0_lo", mif.lo, 32'hffff_fffd);
    go(3'd5, 32'h1234, 32'd0);
    check("mthi_busy", 32'(mif.busy), 0);
    check("mthi_hi", mif.hi, 32'h1234);
    go(3'd1, 32'd100, 32'd7);
    go(3'd6, 32'hdead_beef, 32'd0);
    count_busy(n);
    check("mult_mtlo_cycles", 32'(n), 4);
    check("mult_mtlo_hi", mif.hi, 32'd0);
    check("mult_mtlo_lo", mif.lo, 32'd700);
    go(3'd3, 32'h8000_0000, 32'hffff_ffff);
    count_busy(n);
    check("divovf_hi", mif.hi, 32'd0);
    check("divovf_lo", mif.lo, 32'h8000_0000);
    go(3'd1, 32'd6, 32'd7);
    count_busy(n);
    check("b2b_mult_lo", mif.lo, 32'd42);
    go(3'd4, 32'd100, 32'd7);
    count_busy(n);
    check("b2b_divu_cycles", 32'(n), 10);
    check("b2b_divu_hi", mif.hi, 32'd2);
    check("b2b_divu_lo", mif.lo, 32'd14);
    go(3'd3, 32'd1000, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(mif.busy), 0);
    check("abort_hi", mif.hi, 0);
    check("abort_lo", mif.lo, 0);
    repeat (12) @(negedge clk);
    check("abort_late_hi", mif.hi, 0);
    check("abort_late_lo", mif.lo, 0);
    repeat (1500) begin
      case ($urandom_range(0, 9))
        0: x = 32'h8000_0000;
        1: x = $urandom_range(0, 50);
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: y = 32'hffff_ffff;
        2: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      mif.start = $urandom_range(0, 1) == 1;
      mif.mdop = 3'($urandom_range(0, 7));
      mif.a = x;
      mif.b = y;
      reset = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    mif.start = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
